// File: rtl/video_pattern_gen.sv
// Multi-mode animated video test pattern generator: timing coordinates in,
// RGB out through a fixed two-stage pipeline, mode and scroll latched per frame.
module video_pattern_gen #(
  parameter int COLOR_BITS  = 4,
  parameter int BAND_HEIGHT = 100,
  parameter int BAR_WIDTH   = 128,
  parameter int CHECK_SHIFT = 5,
  parameter int SCROLL_STEP = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           x,
  input  logic [15:0]           y,
  input  logic                  visible,
  input  logic                  frame_start,
  input  logic [1:0]            mode_req,
  input  logic                  freeze,
  output logic [COLOR_BITS-1:0] r,
  output logic [COLOR_BITS-1:0] g,
  output logic [COLOR_BITS-1:0] b,
  output logic                  out_visible
);

  localparam logic [COLOR_BITS-1:0] FS   = '1;
  localparam logic [15:0]           STEP = 16'(SCROLL_STEP);

  logic [1:0]  active_mode;
  logic [15:0] scroll;
  logic [1:0]  eff_mode;
  logic [15:0] eff_scroll;

  logic [15:0] s1_x;
  logic [15:0] s1_y;
  logic        s1_vis;
  logic [1:0]  s1_mode;
  logic [15:0] s1_xs;

  // Mode and scroll take effect on the frame_start pixel itself.
  always_comb begin
    eff_mode   = active_mode;
    eff_scroll = scroll;
    if (frame_start) begin
      eff_mode   = mode_req;
      eff_scroll = freeze ? scroll : scroll + STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_mode <= 2'd0;
      scroll      <= 16'd0;
      s1_x        <= 16'd0;
      s1_y        <= 16'd0;
      s1_vis      <= 1'b0;
      s1_mode     <= 2'd0;
      s1_xs       <= 16'd0;
    end else begin
      active_mode <= eff_mode;
      scroll      <= eff_scroll;
      s1_x        <= x;
      s1_y        <= y;
      s1_vis      <= visible;
      s1_mode     <= eff_mode;
      s1_xs       <= x + eff_scroll;
    end
  end

  logic [COLOR_BITS-1:0] ramp;
  logic [COLOR_BITS-1:0] fine;
  logic [COLOR_BITS-1:0] grey;
  logic [1:0]            quad;
  logic [31:0]           x32;
  logic [31:0]           y32;
  logic [2:0]            band;
  logic [2:0]            bar;

  assign ramp = s1_x[COLOR_BITS+1:2];
  assign fine = s1_x[COLOR_BITS-1:0];
  assign grey = s1_xs[COLOR_BITS+1:2];
  assign quad = s1_x[COLOR_BITS+3:COLOR_BITS+2];
  assign x32  = {16'd0, s1_x};
  assign y32  = {16'd0, s1_y};

  // Threshold chains instead of dividers; scanning downward leaves the lowest hit.
  always_comb begin
    band = 3'd7;
    bar  = 3'd7;
    for (int i = 7; i >= 1; i--) begin
      if (y32 < 32'(i * BAND_HEIGHT)) band = 3'(i - 1);
      if (x32 < 32'(i * BAR_WIDTH))   bar  = 3'(i - 1);
    end
  end

  logic [COLOR_BITS-1:0] cr;
  logic [COLOR_BITS-1:0] cg;
  logic [COLOR_BITS-1:0] cb;
  logic [2:0]            mask;

  always_comb begin
    cr   = '0;
    cg   = '0;
    cb   = '0;
    mask = 3'b000;
    case (s1_mode)
      2'd0: begin
        case (band)
          3'd0:    mask = 3'b100;
          3'd1:    mask = 3'b010;
          3'd2:    mask = 3'b001;
          3'd3:    mask = 3'b110;
          3'd4:    mask = 3'b101;
          3'd5:    mask = 3'b011;
          3'd6:    mask = 3'b111;
          default: mask = 3'b000;
        endcase
        if (band == 3'd7) begin
          cr = (quad == 2'd0 || quad == 2'd3) ? fine : '0;
          cg = (quad == 2'd1 || quad == 2'd3) ? fine : '0;
          cb = (quad == 2'd2 || quad == 2'd3) ? fine : '0;
        end else begin
          cr = mask[2] ? ramp : '0;
          cg = mask[1] ? ramp : '0;
          cb = mask[0] ? ramp : '0;
        end
      end
      2'd1: begin
        case (bar)
          3'd0:    mask = 3'b111;
          3'd1:    mask = 3'b110;
          3'd2:    mask = 3'b011;
          3'd3:    mask = 3'b010;
          3'd4:    mask = 3'b101;
          3'd5:    mask = 3'b100;
          3'd6:    mask = 3'b001;
          default: mask = 3'b000;
        endcase
        cr = mask[2] ? FS : '0;
        cg = mask[1] ? FS : '0;
        cb = mask[0] ? FS : '0;
      end
      2'd2: begin
        if (s1_xs[CHECK_SHIFT] ^ s1_y[CHECK_SHIFT]) begin
          cr = FS;
          cg = FS;
          cb = FS;
        end
      end
      default: begin
        cr = grey;
        cg = grey;
        cb = grey;
      end
    endcase
    if (!s1_vis) begin
      cr = '0;
      cg = '0;
      cb = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r           <= '0;
      g           <= '0;
      b           <= '0;
      out_visible <= 1'b0;
    end else begin
      r           <= cr;
      g           <= cg;
      b           <= cb;
      out_visible <= s1_vis;
    end
  end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen: directed steps plus random pixels against an
// arithmetic reference model, with a second instance whose scroll step wraps.
module tb_video_pattern_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] x;
  logic [15:0] y;
  logic        visible;
  logic        frame_start;
  logic [1:0]  mode_req;
  logic        freeze;
  logic [3:0]  r, g, b;
  logic        out_visible;
  logic [3:0]  r2, g2, b2;
  logic        out_visible2;

  int total = 0;
  int bad   = 0;

  int m_mode   = 0;
  int m_scroll = 0;
  logic [12:0] exp_q[$];

  int band_tab[7] = '{4, 2, 1, 6, 5, 3, 7};
  int bar_tab[8]  = '{7, 6, 3, 2, 5, 4, 1, 0};

  always #5 clk = ~clk;

  video_pattern_gen u_dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .visible(visible),
    .frame_start(frame_start), .mode_req(mode_req), .freeze(freeze),
    .r(r), .g(g), .b(b), .out_visible(out_visible)
  );

  video_pattern_gen #(.SCROLL_STEP(65535)) u_wrap (
    .clk(clk), .reset(reset), .x(x), .y(y), .visible(visible),
    .frame_start(frame_start), .mode_req(mode_req), .freeze(freeze),
    .r(r2), .g(g2), .b(b2), .out_visible(out_visible2)
  );

  function automatic logic [12:0] pk(input int v, input int rr, input int gg, input int bb);
    return {1'(v), 4'(rr), 4'(gg), 4'(bb)};
  endfunction

  function automatic logic [12:0] model(input int mode, input int px, input int py,
                                        input int xs, input bit vis);
    int rr, gg, bb, ramp, fine, band, bar, q, msk, c;
    rr = 0; gg = 0; bb = 0;
    if (!vis) return 13'd0;
    ramp = (px >> 2) & 15;
    fine = px & 15;
    case (mode)
      0: begin
        band = py / 100;
        if (band < 7) begin
          msk = band_tab[band];
          rr = ((msk & 4) != 0) ? ramp : 0;
          gg = ((msk & 2) != 0) ? ramp : 0;
          bb = ((msk & 1) != 0) ? ramp : 0;
        end else begin
          q  = (px >> 6) & 3;
          rr = (q == 0 || q == 3) ? fine : 0;
          gg = (q == 1 || q == 3) ? fine : 0;
          bb = (q == 2 || q == 3) ? fine : 0;
        end
      end
      1: begin
        bar = px / 128;
        if (bar > 7) bar = 7;
        msk = bar_tab[bar];
        rr = ((msk & 4) != 0) ? 15 : 0;
        gg = ((msk & 2) != 0) ? 15 : 0;
        bb = ((msk & 1) != 0) ? 15 : 0;
      end
      2: begin
        c  = ((xs >> 5) ^ (py >> 5)) & 1;
        rr = c * 15; gg = rr; bb = rr;
      end
      default: begin
        rr = (xs >> 2) & 15; gg = rr; bb = rr;
      end
    endcase
    return pk(1, rr, gg, bb);
  endfunction

  // One pixel per clock; the output seen after the edge belongs to the previous step.
  task automatic step(input int px, input int py, input bit pv, input bit pfs,
                      input int pm, input bit pfr, input bit prst);
    logic [12:0] e;
    int xs;
    x = 16'(px); y = 16'(py); visible = pv; frame_start = pfs;
    mode_req = 2'(pm); freeze = pfr; reset = prst;
    if (prst) begin
      m_mode = 0; m_scroll = 0;
      exp_q.delete();
      exp_q.push_back(13'd0);
      exp_q.push_back(13'd0);
    end else begin
      if (pfs) begin
        m_mode = pm;
        if (!pfr) m_scroll = (m_scroll + 1) % 65536;
      end
      xs = (px + m_scroll) % 65536;
      exp_q.push_back(model(m_mode, px, py, xs, pv));
    end
    @(posedge clk);
    #1;
    if (exp_q.size() >= 2) begin
      e = exp_q.pop_front();
      total++;
      assert ({out_visible, r, g, b} === e)
      else begin
        bad++;
        $error("FAIL pixel obs=%h exp=%h", {out_visible, r, g, b}, e);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [12:0] e);
    total++;
    assert ({out_visible, r, g, b} === e)
    else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, {out_visible, r, g, b}, e);
    end
  endtask

  task automatic chk_w(input string tag, input logic [12:0] e);
    total++;
    assert ({out_visible2, r2, g2, b2} === e)
    else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, {out_visible2, r2, g2, b2}, e);
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // reset behaviour
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0, 1);
    chk("reset", 13'd0);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 1, 0, 0, 0, 0);
      if (i == 0) chk("rst_lat1", 13'd0);
      if (i == 1) chk("rst_lat2", pk(1, 0, 0, 0));
    end

    // mode 0 gradient bands
    step(20, 50, 1, 0, 0, 0, 0);
    step(20, 350, 1, 0, 0, 0, 0);
    chk("m0_band0", pk(1, 5, 0, 0));
    step(70, 750, 1, 0, 0, 0, 0);
    chk("m0_band3", pk(1, 5, 5, 0));
    step(200, 750, 1, 0, 0, 0, 0);
    chk("m0_q1", pk(1, 0, 6, 0));
    idle();
    chk("m0_q3", pk(1, 8, 8, 8));

    // mode 1 bars; freeze held on this frame_start keeps scroll at 0
    step(0, 0, 1, 1, 1, 1, 0);
    step(300, 0, 1, 0, 1, 0, 0);
    chk("m1_white", pk(1, 15, 15, 15));
    step(900, 0, 1, 0, 1, 0, 0);
    chk("m1_cyan", pk(1, 0, 15, 15));
    step(1100, 0, 1, 0, 1, 0, 0);
    chk("m1_bar7", pk(1, 0, 0, 0));
    idle();
    chk("m1_clamp", pk(1, 0, 0, 0));

    // mode request outside frame_start is ignored
    step(300, 0, 1, 0, 2, 0, 0);
    step(300, 0, 1, 0, 2, 0, 0);
    chk("no_switch", pk(1, 0, 15, 15));

    // switch to checkerboard at frame_start, scroll becomes 1
    step(0, 0, 1, 1, 2, 0, 0);
    step(32, 0, 1, 0, 2, 0, 0);
    chk("m2_fs_pix", pk(1, 0, 0, 0));
    step(32, 0, 0, 0, 2, 0, 0);
    chk("m2_x32", pk(1, 15, 15, 15));
    idle();
    chk("invisible", 13'd0);

    // mode 3 grey ramp after three frames from reset
    step(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 3, 0, 0);
    step(0, 0, 1, 0, 3, 0, 0);
    step(9, 0, 1, 0, 3, 0, 0);
    chk("m3_x0", pk(1, 0, 0, 0));
    chk_w("wrap_x0", pk(1, 15, 15, 15));
    idle();
    chk("m3_x9", pk(1, 3, 3, 3));
    chk_w("wrap_x9", pk(1, 1, 1, 1));

    // freeze across two frame_starts
    step(0, 0, 0, 1, 3, 1, 0);
    step(0, 0, 0, 1, 3, 1, 0);
    step(9, 0, 1, 0, 3, 0, 0);
    idle();
    chk("frozen", pk(1, 3, 3, 3));
    chk_w("frozen_wrap", pk(1, 1, 1, 1));

    // reset mid-frame while in mode 2
    step(0, 0, 1, 1, 2, 0, 0);
    step(40, 0, 1, 0, 2, 0, 0);
    step(40, 0, 1, 0, 2, 0, 1);
    step(20, 50, 1, 0, 2, 0, 0);
    idle();
    chk("post_reset", pk(1, 5, 0, 0));

    // random pixels against the model
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 1500), $urandom_range(0, 1100),
           $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 3), $urandom_range(0, 3) == 0,
           $urandom_range(0, 99) == 0);
    end
    idle();
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
